// File: rtl/vga_mem_arbiter.sv
// Single-port pixel-memory arbiter: VGA scanout reads have fixed priority, host gets blanking slots.
// Optional host read path is enabled by defining VGA_ARB_HOST_READ_EN; otherwise the host port is write-only.
module vga_mem_arbiter #(
   parameter int H_VIDEO       = 640,
   parameter int V_VIDEO       = 480,
   parameter int ADDR_WIDTH    = 19,
   parameter int DATA_WIDTH    = 8,
   parameter int COUNTER_WIDTH = 10
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     will_display,
   input  logic [COUNTER_WIDTH-1:0] v_counter_next,
   output logic [ADDR_WIDTH-1:0]    mem_addr,
   output logic                     mem_we,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   input  logic [DATA_WIDTH-1:0]    mem_rdata,
   output logic [DATA_WIDTH-1:0]    pixel,
   output logic                     pixel_valid,
   input  logic                     host_valid,
   output logic                     host_ready,
   input  logic                     host_we,
   input  logic [ADDR_WIDTH-1:0]    host_addr,
   input  logic [DATA_WIDTH-1:0]    host_wdata,
   output logic [DATA_WIDTH-1:0]    host_rdata,
   output logic                     host_rvalid,
   output logic                     host_err
);

   localparam int unsigned PIXELS = H_VIDEO * V_VIDEO;

   typedef enum logic [1:0] {OWN_IDLE, OWN_SCAN, OWN_HOST} owner_t;

`ifdef VGA_ARB_HOST_READ_EN
   typedef enum logic [1:0] {TAG_NONE, TAG_SCAN, TAG_HOST, TAG_HOST_ERR} rtag_t;
`else
   typedef enum logic {TAG_NONE, TAG_SCAN} rtag_t;
`endif

   owner_t                owner;
   rtag_t                 rtag;
   logic [ADDR_WIDTH-1:0] scan_addr;
   logic                  err_q;
   logic                  in_range;
   logic                  v_blank;

   assign in_range = {1'b0, host_addr} < (ADDR_WIDTH + 1)'(PIXELS);
   assign v_blank  = v_counter_next >= COUNTER_WIDTH'(V_VIDEO);

   assign host_ready = reset & ~will_display;

   always_comb begin
      owner = OWN_IDLE;
      if (reset) begin
         if (will_display)
            owner = OWN_SCAN;
         else if (host_valid)
            owner = OWN_HOST;
      end
   end

   always_comb begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      case (owner)
         OWN_SCAN: mem_addr = scan_addr;
         OWN_HOST: begin
`ifdef VGA_ARB_HOST_READ_EN
            mem_addr = host_addr;
            if (host_we) begin
               mem_we    = in_range;
               mem_wdata = host_wdata;
            end
`else
            // Reads have no memory access in the write-only build.
            if (host_we) begin
               mem_addr  = host_addr;
               mem_we    = in_range;
               mem_wdata = host_wdata;
            end
`endif
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         scan_addr <= '0;
         rtag      <= TAG_NONE;
         err_q     <= 1'b0;
      end else begin
         if (v_blank)
            scan_addr <= '0;
         else if (owner == OWN_SCAN)
            scan_addr <= scan_addr + ADDR_WIDTH'(1);

         err_q <= (owner == OWN_HOST) && !in_range;

         case (owner)
            OWN_SCAN: rtag <= TAG_SCAN;
`ifdef VGA_ARB_HOST_READ_EN
            OWN_HOST: begin
               if (host_we)
                  rtag <= TAG_NONE;
               else if (in_range)
                  rtag <= TAG_HOST;
               else
                  rtag <= TAG_HOST_ERR;
            end
`endif
            default:  rtag <= TAG_NONE;
         endcase
      end
   end

   // Return outputs are gated by reset so a return in flight across a reset edge is dropped.
   assign pixel_valid = reset && (rtag == TAG_SCAN);
   assign pixel       = pixel_valid ? mem_rdata : '0;
   assign host_err    = reset & err_q;

`ifdef VGA_ARB_HOST_READ_EN
   assign host_rvalid = reset && ((rtag == TAG_HOST) || (rtag == TAG_HOST_ERR));
   assign host_rdata  = (reset && (rtag == TAG_HOST)) ? mem_rdata : '0;
`else
   assign host_rvalid = 1'b0;
   assign host_rdata  = '0;
`endif

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Randomised self-checking bench for vga_mem_arbiter on a reduced 32x24 raster.
// Honours VGA_ARB_HOST_READ_EN the same way as the design.
module tb_vga_mem_arbiter;

   localparam int H   = 32;
   localparam int V   = 24;
   localparam int HT  = 40;
   localparam int VT  = 28;
   localparam int AW  = 10;
   localparam int DW  = 8;
   localparam int CW  = 10;
   localparam int PIX = H * V;

`ifdef VGA_ARB_HOST_READ_EN
   localparam bit RD_EN = 1'b1;
`else
   localparam bit RD_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          will_display;
   logic [CW-1:0] v_counter_next;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic [DW-1:0] pixel;
   logic          pixel_valid;
   logic          host_valid;
   logic          host_ready;
   logic          host_we;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata;
   logic [DW-1:0] host_rdata;
   logic          host_rvalid;
   logic          host_err;

   vga_mem_arbiter #(
      .H_VIDEO      (H),
      .V_VIDEO      (V),
      .ADDR_WIDTH   (AW),
      .DATA_WIDTH   (DW),
      .COUNTER_WIDTH(CW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .will_display  (will_display),
      .v_counter_next(v_counter_next),
      .mem_addr      (mem_addr),
      .mem_we        (mem_we),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata),
      .pixel         (pixel),
      .pixel_valid   (pixel_valid),
      .host_valid    (host_valid),
      .host_ready    (host_ready),
      .host_we       (host_we),
      .host_addr     (host_addr),
      .host_wdata    (host_wdata),
      .host_rdata    (host_rdata),
      .host_rvalid   (host_rvalid),
      .host_err      (host_err)
   );

   always #5 clk = ~clk;

   // Synchronous single-port RAM: read data valid one cycle after the address.
   logic [DW-1:0] ram    [0:(1<<AW)-1];
   logic [DW-1:0] shadow [0:(1<<AW)-1];

   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   int h, v, pv_count;
   logic          e_pv, e_rv, e_err;
   logic [DW-1:0] e_pix, e_rd;

   // mode 0: raster from the timing model; 1: display forced; 2: blanking forced
   task automatic cycle(input bit rst, input int mode, input bit hv, input bit hwe,
                        input int ha, input int hwd);
      int hn, vn, vdrv, exp_addr;
      bit wd, acc, inr, exp_we;
      hn = (h == HT - 1) ? 0 : h + 1;
      vn = (h == HT - 1) ? ((v == VT - 1) ? 0 : v + 1) : v;
      if (mode == 0) begin
         wd   = (hn < H) && (vn < V);
         vdrv = vn;
      end else begin
         wd   = (mode == 1);
         vdrv = V;
      end
      reset          = rst;
      will_display   = wd;
      v_counter_next = CW'(vdrv);
      host_valid     = hv;
      host_we        = hwe;
      host_addr      = AW'(ha);
      host_wdata     = DW'(hwd);

      @(negedge clk);
      acc      = rst && !wd && hv;
      inr      = ha < PIX;
      exp_addr = 0;
      exp_we   = 1'b0;
      if (rst && wd)
         exp_addr = vn * H + hn;
      else if (acc && (hwe || RD_EN)) begin
         exp_addr = ha;
         exp_we   = hwe && inr;
      end

      check("host_ready", host_ready, rst && !wd);
      check("mem_addr", mem_addr, exp_addr);
      check("mem_we", mem_we, exp_we);
      if (exp_we) check("mem_wdata", mem_wdata, hwd & 8'hFF);
      check("pixel_valid", pixel_valid, rst ? e_pv : 1'b0);
      check("pixel", pixel, rst ? e_pix : '0);
      check("host_rvalid", host_rvalid, rst ? e_rv : 1'b0);
      check("host_rdata", host_rdata, rst ? e_rd : '0);
      check("host_err", host_err, rst ? e_err : 1'b0);

      if (pixel_valid) pv_count++;
      if (mode == 0 && rst && h == 0 && v == V) begin
         check("frame_pixels", pv_count, PIX);
         pv_count = 0;
      end

      e_pv  = rst && wd;
      e_pix = e_pv ? shadow[exp_addr] : '0;
      e_rv  = acc && !hwe && RD_EN;
      e_rd  = (e_rv && inr) ? shadow[ha] : '0;
      e_err = acc && !inr;
      if (exp_we) shadow[ha] = DW'(hwd);

      @(posedge clk);
      #1;
      if (!rst || mode != 0) begin
         h        = HT - 1;
         v        = VT - 1;
         pv_count = 0;
      end else begin
         h = hn;
         v = vn;
      end
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) begin
         ram[i]    = DW'(i);
         shadow[i] = DW'(i);
      end
      h = HT - 1; v = VT - 1; pv_count = 0;
      e_pv = 1'b0; e_rv = 1'b0; e_err = 1'b0; e_pix = '0; e_rd = '0;
      reset = 1'b0; will_display = 1'b1; v_counter_next = '0;
      host_valid = 1'b1; host_we = 1'b1; host_addr = '0; host_wdata = '0;

      // Reset held with competing requests
      repeat (3) cycle(1'b0, 1, 1'b1, 1'b1, 3, 8'hA5);

      // Directed host traffic in blanking
      cycle(1'b1, 2, 1'b1, 1'b1, 100, 8'h5A);
      cycle(1'b1, 2, 1'b1, 1'b0, 100, 0);
      cycle(1'b1, 2, 1'b1, 1'b1, PIX, 8'h33);
      cycle(1'b1, 2, 1'b1, 1'b0, PIX, 0);
      cycle(1'b1, 2, 1'b1, 1'b0, PIX - 1, 0);
      cycle(1'b1, 2, 1'b1, 1'b0, 0, 0);
      cycle(1'b1, 2, 1'b0, 1'b0, 0, 0);

      // Read accepted, then reset on the following edge
      cycle(1'b1, 2, 1'b1, 1'b0, 100, 0);
      cycle(1'b0, 2, 1'b0, 1'b0, 0, 0);
      cycle(1'b1, 2, 1'b0, 1'b0, 0, 0);

      // Three frames of raster with random host traffic
      repeat (3 * HT * VT) begin
         int ha;
         if ($urandom_range(0, 7) == 0) ha = int'($urandom_range(PIX, (1 << AW) - 1));
         else                           ha = int'($urandom_range(0, PIX - 1));
         cycle(1'b1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ha,
               int'($urandom_range(0, 255)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vga_mem_arbiter.md
# vga_mem_arbiter

Single-port pixel-memory arbiter between VGA scanout and a host port. Sits beside the `vga` timing generator: uses its `will_display` and next-counter outputs to issue one scanout read per displayed pixel, with fixed priority over the host. The host gets read/write access only in blanking slots, through a valid/ready handshake. Pixel data leaves the block aligned with the registered timing counters.

## Interface
- `H_VIDEO`, 640, active pixels per line (scan address stride)
- `V_VIDEO`, 480, active lines per frame
- `ADDR_WIDTH`, 19, memory/host address width; must satisfy 2^ADDR_WIDTH >= H_VIDEO*V_VIDEO
- `DATA_WIDTH`, 8, pixel word width
- `COUNTER_WIDTH`, 10, width of timing-counter inputs
- `clk`  in  1  sole clock; all state on rising edge
- `reset`  in  1  synchronous, active-low reset
- `will_display`  in  1  from timing generator: next cycle is a displayed pixel
- `v_counter_next`  in  COUNTER_WIDTH  from timing generator
- `mem_addr`  out  ADDR_WIDTH  memory address
- `mem_we`  out  1  memory write strobe
- `mem_wdata`  out  DATA_WIDTH  memory write data
- `mem_rdata`  in  DATA_WIDTH  memory read data, valid 1 cycle after address
- `pixel`  out  DATA_WIDTH  colour for current pixel; 0 in blanking
- `pixel_valid`  out  1  `pixel` is a displayed pixel
- `host_valid`  in  1  host request
- `host_ready`  out  1  request accepted this cycle when valid & ready
- `host_we`  in  1  1 = write, 0 = read
- `host_addr`  in  ADDR_WIDTH  host address
- `host_wdata`  in  DATA_WIDTH  host write data
- `host_rdata`  out  DATA_WIDTH  read data, valid with `host_rvalid`
- `host_rvalid`  out  1  one-cycle read-return pulse
- `host_err`  out  1  one-cycle pulse: accepted request had out-of-range address

## Operation
- Slot owner per cycle (combinational): `will_display`=1 -> SCAN; else HOST if `host_valid`; else IDLE (`mem_addr`=0, `mem_we`=0).
- `host_ready` = reset deasserted & ~`will_display`. Host never stalls scanout.
- Scan address generator: register `scan_addr`. SCAN cycle: `mem_addr`=`scan_addr`, `scan_addr`<=`scan_addr`+1. While `v_counter_next` >= V_VIDEO: `scan_addr`<=0. Yields linear address v*H_VIDEO+h.
- Host write accepted: `mem_addr`=`host_addr`, `mem_we`=1, `mem_wdata`=`host_wdata` in the same cycle.
- Host read accepted: `mem_addr`=`host_addr`, `mem_we`=0; return tracked in the read pipeline.
- Out-of-range address (>= H_VIDEO*V_VIDEO): accepted, `mem_we` forced 0, `host_err` pulses next cycle; a read still returns `host_rvalid` with `host_rdata`=0.
- Read-return tag register `rtag` in {NONE, SCAN, HOST, HOST_ERR}, loaded each cycle from the slot owner/op. Next cycle: SCAN -> `pixel`=`mem_rdata`, `pixel_valid`=1; HOST -> `host_rdata`=`mem_rdata`, `host_rvalid`=1; HOST_ERR -> `host_rdata`=0, `host_rvalid`=1. `pixel`=0 unless tag SCAN; `host_rdata` is 0 when `host_rvalid`=0.
- Back-to-back host requests accepted every non-display cycle; reads are fully pipelined.

## Timing
- Reset (`reset`=0 at a clock edge): `scan_addr`=0, `rtag`=NONE; all outputs 0 the following cycle, including `host_ready`. An in-flight read return is discarded (no `host_rvalid`).
- Scanout latency: request on the cycle `will_display`=1; `pixel`/`pixel_valid` one cycle later, aligned with the timing generator's registered counters.
- Host write latency 0 (memory written at the accepting edge). Host read latency 1: `host_rvalid` the cycle after acceptance.
- `host_err` one cycle after acceptance.
- First displayed pixel of a frame reads address 0. The last pixel reads H_VIDEO*V_VIDEO-1.

## Configuration
- `VGA_ARB_HOST_READ_EN` defined: host reads as above.
- Undefined: host port is write-only. A request with `host_we`=0 is accepted and ignored (no memory access). `host_rvalid` and `host_rdata` are tied 0, and the HOST/HOST_ERR return tags are not built. `host_err` still pulses for out-of-range accepted reads and writes.

## Test plan
- Reset check: hold `reset`=0 for 3 cycles with `host_valid`=1 and `will_display`=1 -> all outputs 0, no `mem_we`; first scan read after release uses address 0.
- Full frame with a 640x480 timing generator and memory preloaded with addr[7:0] -> `pixel` at displayed (h,v) equals (v*640+h)[7:0]; `pixel_valid` count per frame is 307200.
- Host contention: `host_valid` held during active video -> `host_ready`=0 for 640 cycles per line; the write lands in the first blanking cycle; no pixel corrupted.
- Host write 0x5A to address 1000 in blanking, then read 1000 -> `host_rvalid` the cycle after acceptance, with `host_rdata`=0x5A.
- Out-of-range: host write to 307200 -> `mem_we`=0, `host_err` pulse; a read to 307200 -> `host_rvalid` with `host_rdata`=0.
- Reset mid-read: accept a read, then assert `reset`=0 the next edge -> no `host_rvalid`; with `VGA_ARB_HOST_READ_EN` undefined, a read request gives no `host_rvalid` at all.
